// File: rtl/axis_uart_tx_arbiter.sv
// rtl/axis_uart_tx_arbiter.sv - round-robin arbiter sharing one AXI-Stream UART TX among NUM_REQ sources
// Holds each grant until the transmitter reports frame completion or the watchdog expires.
module axis_uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int ID_W          = $clog2(NUM_REQ),
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_REQ-1:0]            s_tready,
    output logic                          m_tvalid,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    input  logic                          m_tready,
    input  logic                          tx_done,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    any_valid;
    logic [ID_W-1:0]         winner;

    // Scan starts just after the previous winner, so priority rotates only on a grant.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_valid && s_tvalid[(int'(last_q) + k) % NUM_REQ]) begin
                any_valid = 1'b1;
                winner    = ID_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (state_q == IDLE && any_valid) begin
            s_tready = NUM_REQ'(1) << winner;
        end
    end

    always_comb begin
        state_d       = state_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    m_tdata_d  = s_tdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d = winner;
                    last_d     = winner;
                    m_tvalid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // tx_done here belongs to no word of ours and is deliberately ignored.
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    m_tdata_d  = '0;
                    cnt_d      = '0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_done) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            grant_id_q    <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
